// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO; frame format is sampled when each word
// is popped, so configuration changes take effect on the next frame only.
module uart_tx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          two_stop,
    output logic                          TxD,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    state_t state_reg, state_next;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]     count_reg;
    logic [DATA_BITS-1:0] word_reg;
    logic                 parity_en_reg, parity_odd_reg, two_stop_reg;
    logic [BAUD_W-1:0]    baud_reg;
    logic [BIT_W-1:0]     bit_reg, bit_next;
    logic                 txd_reg, txd_next;
    logic                 push, pop, bit_end, fifo_nempty, parity_bit;

    assign tx_ready    = (count_reg < CNT_W'(FIFO_DEPTH));
    assign push        = tx_valid && tx_ready;
    assign fifo_nempty = (count_reg != '0);
    assign bit_end     = (baud_reg == BAUD_LAST);
    assign parity_bit  = parity_odd_reg ? ~^word_reg : ^word_reg;

    assign fifo_count = count_reg;
    assign busy       = (state_reg != IDLE) || fifo_nempty;
    assign TxD        = txd_reg;

    // Storage and the registered head read carry no reset so they map onto RAM.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= tx_data;
        if (pop)
            word_reg <= mem[rd_ptr_reg];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            parity_en_reg  <= 1'b0;
            parity_odd_reg <= 1'b0;
            two_stop_reg   <= 1'b0;
            baud_reg       <= '0;
            bit_reg        <= '0;
            txd_reg        <= 1'b1;
        end else begin
            state_reg <= state_next;
            bit_reg   <= bit_next;
            txd_reg   <= txd_next;
            baud_reg  <= (state_reg == IDLE || bit_end) ? '0 : baud_reg + BAUD_W'(1);
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop) begin
                rd_ptr_reg     <= rd_ptr_reg + PTR_W'(1);
                parity_en_reg  <= parity_en;
                parity_odd_reg <= parity_odd;
                two_stop_reg   <= two_stop;
            end
            if (push && !pop)
                count_reg <= count_reg + CNT_W'(1);
            else if (pop && !push)
                count_reg <= count_reg - CNT_W'(1);
        end
    end

    // Next-state logic; the final stop bit chains straight into the next START.
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fifo_nempty) begin
                    state_next = START;
                    pop        = 1'b1;
                end
            end
            START:  if (bit_end) state_next = DATA;
            DATA: begin
                if (bit_end && bit_reg == BIT_LAST)
                    state_next = parity_en_reg ? PARITY : STOP1;
            end
            PARITY: if (bit_end) state_next = STOP1;
            STOP1, STOP2: begin
                if (bit_end) begin
                    if (state_reg == STOP1 && two_stop_reg) begin
                        state_next = STOP2;
                    end else if (fifo_nempty) begin
                        state_next = START;
                        pop        = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Line level is computed from the upcoming state so TxD can be a flop.
    always_comb begin
        bit_next = bit_reg;
        if (state_reg == DATA && bit_end)
            bit_next = (bit_reg == BIT_LAST) ? '0 : bit_reg + BIT_W'(1);
        case (state_next)
            START:   txd_next = 1'b0;
            DATA:    txd_next = word_reg[bit_next];
            PARITY:  txd_next = parity_bit;
            default: txd_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: expected frames are queued when words are
// enqueued and checked bit by bit as the serial line produces them.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       parity_en, parity_odd, two_stop;
    logic       txd, busy;
    logic [2:0] fifo_count;

    logic [4:0] tx_data5;
    logic       tx_valid5, tx_ready5, txd5, busy5;
    logic [2:0] fifo_count5;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int frame_num = 0;

    typedef struct {
        int sel;
        int nbits;
        int cpb;
        int word;
        bit pen;
        bit podd;
        bit two;
        bit contig;
    } frame_t;

    frame_t exp_q[$];

    always #5 clk = ~clk;

    uart_tx_fifo dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .parity_en(parity_en), .parity_odd(parity_odd),
        .two_stop(two_stop), .TxD(txd), .busy(busy), .fifo_count(fifo_count)
    );

    uart_tx_fifo #(.DATA_BITS(5), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut5 (
        .clk(clk), .reset(reset), .tx_data(tx_data5), .tx_valid(tx_valid5),
        .tx_ready(tx_ready5), .parity_en(parity_en), .parity_odd(parity_odd),
        .two_stop(two_stop), .TxD(txd5), .busy(busy5), .fifo_count(fifo_count5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    function automatic logic txd_of(input int sel);
        return (sel != 0) ? txd5 : txd;
    endfunction

    function automatic void add_frame(input int sel, input int nbits, input int cpb, input int word,
                                      input bit pen, input bit podd, input bit two, input bit contig);
        frame_t f;
        f.sel = sel; f.nbits = nbits; f.cpb = cpb; f.word = word;
        f.pen = pen; f.podd = podd; f.two = two; f.contig = contig;
        exp_q.push_back(f);
    endfunction

    function automatic logic frame_bit(input frame_t e, input int j);
        logic [7:0] w;
        logic       p;
        w = e.word[7:0];
        p = ^w;
        if (j == 0)
            return 1'b0;
        if (j <= e.nbits)
            return w[j-1];
        if (j == e.nbits + 1 && e.pen)
            return e.podd ? ~p : p;
        return 1'b1;
    endfunction

    // Drive one word for one edge, then check the queue depth after that edge.
    task automatic enq(input int sel, input int w, input int exp_cnt);
        @(negedge clk);
        if (sel == 0) begin tx_data = w[7:0]; tx_valid = 1'b1; end
        else begin tx_data5 = w[4:0]; tx_valid5 = 1'b1; end
        @(negedge clk);
        tx_valid  = 1'b0;
        tx_valid5 = 1'b0;
        chk($sformatf("enq_count_w%02h", w), (sel != 0) ? 32'(fifo_count5) : 32'(fifo_count), exp_cnt);
    endtask

    task automatic check_frames(input int n);
        frame_t e;
        int     waited, nb;
        logic   eb, obs, first, bad;
        for (int f = 0; f < n; f++) begin
            if (exp_q.size() == 0) break;
            e = exp_q.pop_front();
            waited = 0;
            @(negedge clk);
            while (txd_of(e.sel) !== 1'b0 && waited < 3000) begin
                waited++;
                @(negedge clk);
            end
            if (waited >= 3000) begin
                chk($sformatf("frame%0d_start_timeout", frame_num), 32'(txd_of(e.sel)), 0);
                return;
            end
            if (e.contig)
                chk($sformatf("frame%0d_gap_cycles", frame_num), waited, 0);
            nb = 2 + e.nbits + int'(e.pen) + int'(e.two);
            for (int j = 0; j < nb; j++) begin
                eb = frame_bit(e, j);
                bad = 1'b0;
                first = eb;
                for (int s = 0; s < e.cpb; s++) begin
                    if (!(j == 0 && s == 0)) @(negedge clk);
                    obs = txd_of(e.sel);
                    if (obs !== eb && !bad) begin bad = 1'b1; first = obs; end
                end
                chk($sformatf("frame%0d_w%02h_bit%0d", frame_num, e.word, j), 32'(first), 32'(eb));
            end
            $display("frame %0d word 0x%02h checked (%0d bits x %0d cycles)", frame_num, e.word, nb, e.cpb);
            frame_num++;
        end
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        chk({tag, "_txd"}, 32'(txd), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_count"}, 32'(fifo_count), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] words [5];
        int lows;
        words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        reset = 1'b1; tx_data = '0; tx_valid = 1'b0; tx_data5 = '0; tx_valid5 = 1'b0;
        parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
        @(negedge clk);
        chk("reset_txd", 32'(txd), 1);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_count", 32'(fifo_count), 0);
        chk("reset_tx_ready", 32'(tx_ready), 1);
        reset = 1'b0;
        @(negedge clk);

        // 8N1 frame; first sample after the pop edge must already be the start bit.
        add_frame(0, 8, 16, 'hA5, 0, 0, 0, 1);
        enq(0, 'hA5, 1);
        chk("latency_txd_idle_at_enq", 32'(txd), 1);
        check_frames(1);
        check_idle("after_a5");

        // Odd then even parity with two stop bits.
        parity_en = 1'b1; parity_odd = 1'b1; two_stop = 1'b1;
        add_frame(0, 8, 16, 'h07, 1, 1, 1, 1);
        enq(0, 'h07, 1);
        check_frames(1);
        check_idle("after_07_odd");
        parity_odd = 1'b0;
        add_frame(0, 8, 16, 'h07, 1, 0, 1, 1);
        enq(0, 'h07, 1);
        check_frames(1);
        check_idle("after_07_even");

        // Back-to-back burst of five plus one word offered while full.
        parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
        for (int i = 0; i < 5; i++)
            add_frame(0, 8, 16, int'(words[i]), 0, 0, 0, i != 0);
        fork
            begin
                @(negedge clk);
                tx_data = words[0]; tx_valid = 1'b1;
                for (int i = 1; i < 5; i++) begin
                    @(negedge clk);
                    chk($sformatf("burst_count_%0d", i), 32'(fifo_count), (i == 1) ? 1 : i - 1);
                    tx_data = words[i];
                end
                @(negedge clk);
                chk("burst_full_count", 32'(fifo_count), 4);
                chk("burst_full_ready", 32'(tx_ready), 0);
                tx_data = 8'hEE;
                @(negedge clk);
                chk("burst_ignored_count", 32'(fifo_count), 4);
                tx_valid = 1'b0;
            end
            check_frames(5);
        join
        check_idle("after_burst");
        lows = 0;
        repeat (200) begin @(negedge clk); if (txd !== 1'b1) lows++; end
        chk("no_extra_frame", lows, 0);

        // Configuration change mid-frame applies only to the following frame.
        add_frame(0, 8, 16, 'h3C, 0, 0, 0, 1);
        add_frame(0, 8, 16, 'hC1, 1, 0, 1, 1);
        enq(0, 'h3C, 1);
        fork
            begin
                repeat (30) @(negedge clk);
                parity_en = 1'b1; parity_odd = 1'b0; two_stop = 1'b1;
                enq(0, 'hC1, 1);
            end
            check_frames(2);
        join
        check_idle("after_cfg_change");
        parity_en = 1'b0; two_stop = 1'b0;

        // Reset during data bit 3 with two words still queued.
        @(negedge clk);
        tx_data = 8'h55; tx_valid = 1'b1;
        @(negedge clk); tx_data = 8'h66;
        @(negedge clk); tx_data = 8'h77;
        @(negedge clk); tx_valid = 1'b0;
        chk("pre_reset_count", 32'(fifo_count), 2);
        repeat (68) @(negedge clk);
        chk("pre_reset_bit3_txd", 32'(txd), 0);
        reset = 1'b1;
        #1;
        chk("midframe_reset_txd", 32'(txd), 1);
        chk("midframe_reset_count", 32'(fifo_count), 0);
        chk("midframe_reset_busy", 32'(busy), 0);
        chk("midframe_reset_ready", 32'(tx_ready), 1);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        lows = 0;
        repeat (400) begin @(negedge clk); if (txd !== 1'b1 || busy !== 1'b0) lows++; end
        chk("post_reset_quiet", lows, 0);

        // Narrow instance: 5 data bits at 4 clocks per bit.
        add_frame(1, 5, 4, 'h1F, 0, 0, 0, 1);
        enq(1, 'h1F, 1);
        check_frames(1);
        @(negedge clk);
        chk("dut5_idle_txd", 32'(txd5), 1);
        chk("dut5_idle_busy", 32'(busy5), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
